// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: multi-cycle controller for the 16-bit ALU datapath.
// Accepts one instruction per start handshake in WAIT. It then steps through register reads,
// the ALU operation, the status load and writeback. Every output is a Moore decode of the
// current state and the latched instruction register (IR).
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   s              start request, sampled only while idle
//   in[15:0]       instruction word, captured into IR on acceptance
//   w              idle/ready
//   done, err      completion pulse / illegal-instruction pulse
//   readnum[2:0]   register-file read address
//   writenum[2:0]  register-file write address
//   write          register-file write enable
//   vsel[1:0]      writeback source (00 = C, 10 = sximm8)
//   loada/b/c/s    A, B, C and status register load enables
//   asel           force ALU A operand to zero
//   ALUop[1:0]     ALU function code
//   shift[1:0]     B-path shifter code
//   sximm8/5       sign-extended immediates from IR
module alu_instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        done,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StGetA,
        StGetB,
        StCalc,
        StWriteReg,
        StWriteImm
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // IR fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_illegal;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_illegal = !(is_mov_imm || is_mov_reg || is_alu);

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StWait;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        w        = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        ALUop    = 2'b00;
        shift    = 2'b00;

        unique case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) begin
                    ir_d    = in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                err = is_illegal;
                if (is_mov_imm) begin
                    state_d = StWriteImm;
                end else if (is_mov_reg || is_mvn) begin
                    // Single-operand instructions skip the A read.
                    state_d = StGetB;
                end else if (is_alu) begin
                    state_d = StGetA;
                end else begin
                    state_d = StWait;
                end
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = StCalc;
            end
            StCalc: begin
                shift = sh;
                loadc = 1'b1;
                if (is_alu) begin
                    ALUop = op;
                    loads = 1'b1;
                end else begin
                    // MOV reg passes B through as 0 + B.
                    asel = 1'b1;
                end
                if (is_cmp) begin
                    done    = 1'b1;
                    state_d = StWait;
                end else begin
                    state_d = StWriteReg;
                end
            end
            StWriteReg: begin
                writenum = rd;
                vsel     = 2'b00;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = StWait;
            end
            StWriteImm: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = StWait;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

endmodule
